// File: rtl/input_act_pkg.sv
// Shared types and elaboration helpers for the input activation stream controller.
package input_act_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } feed_state_t;

    // Number of output beats carried by one FIFO word.
    function automatic int beats(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/input_act_stream_ctrl_fifo.sv
// Synchronous FIFO with registered occupancy and flags. Writes while full are dropped;
// clear discards contents and any same-edge push.
module act_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CW-1:0]    count_n;

    // Qualified push/pop and the occupancy they produce.
    always_comb begin
        push_ok = push & ~full & ~clear;
        pop_ok  = pop & ~empty & ~clear;
        count_n = count + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == CW'(DEPTH));
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/input_act_stream_ctrl.sv
// Input activation stream controller: buffers host words and unpacks them LSB slice
// first into ready/valid beats, in counted or drain-until-empty mode.
//
// state | meaning
// IDLE  | no feed active, waiting for START_FEED with data queued
// SHIFT | presenting beats of the current word on DATA_OUT
// WAIT  | counted feed ran dry between words, waiting for a refill
module input_act_stream_ctrl
    import input_act_pkg::*;
#(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 8,
    parameter int FIFO_DEPTH   = 64,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CLEAR_FIFO,
    input  logic                    FIFO_WR_CMD,
    input  logic [INPUT_WIDTH-1:0]  FIFO_WR_DATA,
    input  logic                    START_FEED,
    input  logic [CNT_W-1:0]        FEED_WORDS,
    input  logic                    DATA_READY,
    output logic                    FIFO_EMPTY,
    output logic                    FIFO_FULL,
    output logic [CNT_W-1:0]        FIFO_COUNT,
    output logic [OUTPUT_WIDTH-1:0] DATA_OUT,
    output logic                    DATA_VALID,
    output logic                    FEED_BUSY,
    output logic                    FEED_DONE
);
    localparam int BEATS = beats(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (INPUT_WIDTH % OUTPUT_WIDTH != 0) begin : g_chk_width
        $error("INPUT_WIDTH must be an integer multiple of OUTPUT_WIDTH");
    end
    if (!is_pow2(FIFO_DEPTH)) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    feed_state_t            state, state_n;
    logic [INPUT_WIDTH-1:0] shreg;
    logic [INPUT_WIDTH-1:0] head_data;
    logic [BW-1:0]          beat_cnt;
    logic [CNT_W-1:0]       words_left, words_n;
    logic                   counted, counted_n;
    logic                   pop, load, shift, done_n;
    logic                   transfer, last_beat;

    act_sync_fifo #(
        .WIDTH (INPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .clear     (CLEAR_FIFO),
        .push      (FIFO_WR_CMD),
        .push_data (FIFO_WR_DATA),
        .pop       (pop),
        .head_data (head_data),
        .empty     (FIFO_EMPTY),
        .full      (FIFO_FULL),
        .count     (FIFO_COUNT)
    );

    assign DATA_VALID = (state == SHIFT);
    assign FEED_BUSY  = (state != IDLE);
    assign DATA_OUT   = shreg[OUTPUT_WIDTH-1:0];
    assign transfer   = DATA_VALID & DATA_READY;
    assign last_beat  = (beat_cnt == BW'(BEATS - 1));

    // Next-state, pop and load decisions; the next word is popped on the same edge
    // as the last beat so consecutive words stream without a bubble.
    always_comb begin
        state_n   = state;
        words_n   = words_left;
        counted_n = counted;
        pop       = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (START_FEED && !FIFO_EMPTY) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    words_n   = FEED_WORDS;
                    counted_n = (FEED_WORDS != '0);
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (transfer) begin
                    if (!last_beat) begin
                        shift = 1'b1;
                    end else begin
                        if (counted) words_n = words_left - CNT_W'(1);
                        if (counted && words_left == CNT_W'(1)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else if (!FIFO_EMPTY) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else if (!counted) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (!FIFO_EMPTY) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            default: state_n = IDLE;
        endcase
        if (CLEAR_FIFO) begin
            state_n = IDLE;
            pop     = 1'b0;
            load    = 1'b0;
            shift   = 1'b0;
            done_n  = 1'b0;
        end
    end

    // State, counters and the shift register that supplies DATA_OUT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            shreg      <= '0;
            beat_cnt   <= '0;
            words_left <= '0;
            counted    <= 1'b0;
            FEED_DONE  <= 1'b0;
        end else begin
            state      <= state_n;
            words_left <= words_n;
            counted    <= counted_n;
            FEED_DONE  <= done_n;
            if (load) begin
                shreg    <= head_data;
                beat_cnt <= '0;
            end else if (shift) begin
                shreg    <= shreg >> OUTPUT_WIDTH;
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

endmodule

// File: doc/input_act_stream_ctrl.md
Name: input_act_stream_ctrl

Overview:
Parametrised successor to the input activation controller. It buffers INPUT_WIDTH-bit activation words written by the host in a synchronous FIFO. On command it unpacks each word into OUTPUT_WIDTH-bit beats, least-significant slice first, toward the MAC array. New over the previous generation: ready/valid backpressure, counted or drain-until-empty feed modes, stall on mid-feed underflow, FIFO occupancy output, and a done pulse.

Parameters:
INPUT_WIDTH, 32, FIFO word width; must be an integer multiple of OUTPUT_WIDTH.
OUTPUT_WIDTH, 8, beat width on DATA_OUT.
FIFO_DEPTH, 64, FIFO entries; power of two, >= 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of FIFO_COUNT and FEED_WORDS (derived, do not override).

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
CLEAR_FIFO  in  1  synchronous flush of FIFO and abort of feed
FIFO_WR_CMD  in  1  write strobe
FIFO_WR_DATA  in  INPUT_WIDTH  write data
START_FEED  in  1  begin feed; sampled only in IDLE
FEED_WORDS  in  CNT_W  words to feed, latched with START_FEED; 0 = drain until empty
DATA_READY  in  1  consumer accepts beat
FIFO_EMPTY  out  1  FIFO holds no words
FIFO_FULL  out  1  FIFO holds FIFO_DEPTH words
FIFO_COUNT  out  CNT_W  current FIFO occupancy
DATA_OUT  out  OUTPUT_WIDTH  current beat
DATA_VALID  out  1  DATA_OUT valid
FEED_BUSY  out  1  state != IDLE
FEED_DONE  out  1  one-cycle pulse on feed completion

Behaviour:
- Reset (async assert, sync release): FIFO pointers and count 0, FIFO_EMPTY=1, FIFO_FULL=0, DATA_OUT=0, DATA_VALID=0, FEED_BUSY=0, FEED_DONE=0, state IDLE.
- BEATS = INPUT_WIDTH/OUTPUT_WIDTH.
- Write: a word is accepted on an edge with FIFO_WR_CMD=1 and FIFO_FULL=0. A write while full is silently dropped; a simultaneous pop on that edge does not rescue it.
- FIFO flags and count are registered and reflect all pushes/pops of the previous edge.
- States: IDLE, SHIFT, WAIT.
- IDLE:
  - START_FEED=1 and FIFO non-empty: pop the head word into the shift register, latch FEED_WORDS into the remaining-word counter, go to SHIFT. DATA_VALID=1 with slice 0 from the next cycle (1-cycle latency).
  - START_FEED=1 and FIFO empty: ignored.
- SHIFT:
  - A beat transfers on an edge with DATA_VALID & DATA_READY. DATA_OUT must hold stable while DATA_VALID=1 and DATA_READY=0.
  - After slice BEATS-1 transfers, decrement the remaining count (counted mode), then:
    - Counted mode and count reaches 0: go to IDLE, DATA_VALID=0, FEED_DONE=1 for one cycle.
    - Otherwise, FIFO non-empty: pop the next word on the same edge and stay in SHIFT. There is no bubble between words.
    - Otherwise, FIFO empty: drain mode goes to IDLE with FEED_DONE=1; counted mode goes to WAIT with DATA_VALID=0.
- WAIT: on the first edge with FIFO non-empty, pop and return to SHIFT (first beat 1 cycle later).
- A write and a pop on the same edge leave FIFO_COUNT unchanged. A write to an empty FIFO in WAIT is popped no earlier than the following edge.
- CLEAR_FIFO:
  - Highest priority after RESET. Empties the FIFO and discards any write on the same edge.
  - Forces IDLE, DATA_VALID=0, FEED_BUSY=0, and no FEED_DONE.
- START_FEED outside IDLE is ignored. FEED_WORDS > FIFO_DEPTH is legal; the block waits for refills.
- Pointer wrap: modulo FIFO_DEPTH. Count distinguishes full from empty.

Decomposition:
- Package input_act_pkg:
  - state enum feed_state_t {IDLE, SHIFT, WAIT}.
  - function beats(in_w, out_w).
  - elaboration checks: INPUT_WIDTH % OUTPUT_WIDTH == 0, FIFO_DEPTH a power of two.
- Sub-module act_sync_fifo (params WIDTH, DEPTH). Handles push/pop/clear/count/flags, with the same CLK/RESET convention.
- The top level holds the FSM, shift register, beat counter and word counter.

Test Plan:
- Write 0x44332211, 0x88776655; START_FEED, FEED_WORDS=0, DATA_READY=1 -> DATA_OUT 11,22,33,44,55,66,77,88 on consecutive cycles starting 1 cycle after start; FEED_DONE pulses once; FIFO_EMPTY=1.
- Write 64 words, then a 65th -> FIFO_FULL=1, FIFO_COUNT=64, 65th dropped; drain -> 256 beats matching the first 64 words.
- Write 0xDDCCBBAA; feed with DATA_READY toggling 1,0,0,1,1,0,1 -> DATA_OUT held stable while stalled; exactly AA,BB,CC,DD transferred.
- FEED_WORDS=3 with 1 word queued -> 4 beats, then WAIT, DATA_VALID=0, FEED_BUSY=1; write 2 words 5 cycles later -> 8 more beats, FEED_DONE, IDLE.
- CLEAR_FIFO asserted mid-word with 10 words queued -> next cycle DATA_VALID=0, FIFO_COUNT=0, FEED_BUSY=0, no FEED_DONE; a new feed after refill outputs the new data only.
- RESET asserted asynchronously mid-feed (between edges) -> outputs zero immediately, FIFO_EMPTY=1; normal feed works after release.
